fp_div_sequencer: RTL

Issue/retire sequencer wrapped around the floating-point divider.
- Accepts one FDV operation from decode over a valid/ready handshake and latches the operands and destination tag.
- Resolves zero-operand cases without iterating; otherwise drives the divider's `run`/operand inputs and holds them stable for the full iteration.
- Captures the quotient when the divider releases `stall` and presents it to writeback over a valid/ready handshake.

---
 rtl/fp_div_sequencer_pkg.sv | 24 ++
 rtl/fp_div_sequencer_classify.sv | 25 ++
 rtl/fp_div_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fp_div_sequencer_pkg.sv
// Shared definitions for the FDV issue/retire sequencer: state encoding,
// IEEE single field positions, flag indices and divider iteration count.
package fp_div_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int FDIV_ITER   = 26;
    localparam int TMO_DEFAULT = 31;

    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int SIGN_BIT = 31;

    localparam int FLAG_XZERO   = 0;
    localparam int FLAG_DIVZERO = 1;
    localparam int FLAG_TIMEOUT = 2;

    localparam logic [7:0] FP_INF_EXP = 8'hFF;

endpackage

// File: rtl/fp_div_sequencer_classify.sv
// Combinational operand classifier: detects zero-exponent dividend/divisor
// and forms the quotient word that bypasses the divider.
module fpdiv_classify
    import fp_div_sequencer_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        xzero,
    output logic        divzero,
    output logic [31:0] fast_z
);

    logic x_exp_zero;
    logic y_exp_zero;

    assign x_exp_zero = (x[EXP_HI:EXP_LO] == '0);
    assign y_exp_zero = (y[EXP_HI:EXP_LO] == '0);

    // A zero dividend takes priority over a zero divisor (0/0 yields 0).
    assign xzero   = x_exp_zero;
    assign divzero = ~x_exp_zero & y_exp_zero;
    assign fast_z  = x_exp_zero ? 32'd0
                                : {x[SIGN_BIT] ^ y[SIGN_BIT], FP_INF_EXP, {EXP_LO{1'b0}}};

endmodule

// File: rtl/fp_div_sequencer.sv
// Issue/retire sequencer around the iterative FP divider: accepts one FDV op,
// resolves zero operands directly, otherwise runs the divider and holds the result.
module fp_div_sequencer
    import fp_div_sequencer_pkg::*;
#(
    parameter int TAGW = 4,
    parameter int TMO  = TMO_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_x,
    input  logic [31:0]     in_y,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_z,
    output logic [TAGW-1:0] out_tag,
    output logic [2:0]      out_flags,
    output logic            div_run,
    output logic [31:0]     div_x,
    output logic [31:0]     div_y,
    input  logic            div_stall,
    input  logic [31:0]     div_z,
    output logic            busy
);

    localparam int CW = $clog2(TMO + 1);

    state_t          state_q, state_d;
    logic [31:0]     x_q, x_d;
    logic [31:0]     y_q, y_d;
    logic [31:0]     z_q, z_d;
    logic [TAGW-1:0] t_q, t_d;
    logic [CW-1:0]   c_q, c_d;
    logic [2:0]      flags_q, flags_d;

    logic        xzero;
    logic        divzero;
    logic [31:0] fast_z;
    logic        in_xfer;
    logic        out_xfer;

    fpdiv_classify u_classify (
        .x       (in_x),
        .y       (in_y),
        .xzero   (xzero),
        .divzero (divzero),
        .fast_z  (fast_z)
    );

    assign in_ready  = (state_q == ST_IDLE) & ~flush;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign div_run   = (state_q == ST_RUN);
    assign div_x     = x_q;
    assign div_y     = y_q;
    assign out_z     = z_q;
    assign out_tag   = t_q;
    assign out_flags = flags_q;

    assign in_xfer  = in_valid & in_ready & ce;
    assign out_xfer = out_valid & out_ready & ce;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        t_d     = t_q;
        c_d     = c_q;
        flags_d = flags_q;
        // Flush overrides ce and any transfer; the held result is simply abandoned.
        if (flush) begin
            state_d = ST_IDLE;
        end else if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_xfer) begin
                        x_d = in_x;
                        y_d = in_y;
                        t_d = in_tag;
                        c_d = '0;
                        if (xzero) begin
                            z_d                   = fast_z;
                            flags_d               = '0;
                            flags_d[FLAG_XZERO]   = 1'b1;
                            state_d               = ST_HOLD;
                        end else if (divzero) begin
                            z_d                   = fast_z;
                            flags_d               = '0;
                            flags_d[FLAG_DIVZERO] = 1'b1;
                            state_d               = ST_HOLD;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    c_d = c_q + CW'(1);
                    if (!div_stall) begin
                        z_d     = div_z;
                        flags_d = '0;
                        state_d = ST_HOLD;
                    end else if (c_q == CW'(TMO)) begin
                        z_d                   = '0;
                        flags_d               = '0;
                        flags_d[FLAG_TIMEOUT] = 1'b1;
                        state_d               = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_xfer) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            t_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            t_q     <= t_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

endmodule
